proc_param: RTL and testbench
=============================

Name: proc_param

Overview:
- Parametrised next-generation processor core for the project.
- Fetches its own 16-bit instructions from a ready-handshaked memory port, using r7 as PC.
- Register width is DATA_W.
- Adds load/store, AND, condition flags and conditional branches on top of mv/mvt/add/sub.
- Sits between the top-level memory/IO fabric and the board glue.

Parameters:
DATA_W, 16, register/bus/data width; legal values are 16 or more.
ADDR_W, 16, memory address width; taken from the low ADDR_W bits of the address register (ADDR_W <= DATA_W).

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
Run  input  1  when low, no new instruction fetch starts
DIN  input  DATA_W  memory read data; instruction in DIN[15:0]
MemReady  input  1  memory accepts/completes the current request this cycle
ADDR  output  ADDR_W  memory address
DOUT  output  DATA_W  memory write data
Rd  output  1  read request
W  output  1  write request
Done  output  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- Reset: asynchronous, active-low.
  - r0..r7 (r7 = PC), IR, G and flags z/n/c clear to 0; state = FETCH.
  - ADDR, DOUT, Rd, W and Done are 0.
  - Reset mid-request drops Rd/W immediately.
- Instruction fields:
  - III = IR[15:13]; Imm = IR[12]; rX = IR[11:9]; rY = IR[2:0].
  - Operand = rY if Imm = 0; otherwise sext(IR[8:0]) to DATA_W.
- Memory handshake:
  - Rd or W is held, with ADDR/DOUT stable, until a rising edge where MemReady = 1.
  - Read data is sampled at that edge. Zero-wait (MemReady already high) is legal.
  - Rd and W are never high together.
- States: FETCH, EXEC, ALU_WB, MEM.
- FETCH:
  - If Run = 0: idle, no request.
  - Otherwise: Rd = 1, ADDR = r7.
  - On MemReady: IR <= DIN[15:0], r7 <= r7 + 1, go to EXEC.
- EXEC, by opcode:
  - 000 mv: rX <= operand; Done; go to FETCH.
  - 001, Imm = 1, mvt: rX <= {IR[7:0], (DATA_W-8) zeros}; Done; FETCH.
  - 001, Imm = 0, branch: cond = IR[11:9].
    - Conditions: 000 always, 001 eq (z), 010 ne (!z), 011 cc (!c), 100 cs (c), 101 pl (!n), 110 mi (n), 111 never.
    - If taken: r7 <= r7 + sext(IR[8:0]), modulo 2^DATA_W.
    - Done; FETCH.
  - 010 add, 011 sub, 110 and: G <= rX op operand; flags update; go to ALU_WB.
  - 100 ld, 101 st: go to MEM.
  - 111: reserved, executes as a no-op; Done; FETCH.
- ALU_WB: rX <= G; Done; FETCH.
- MEM:
  - ld: Rd = 1, ADDR = rY[ADDR_W-1:0]. On MemReady: rX <= DIN; Done; FETCH.
  - st: W = 1, ADDR = rY, DOUT = rX. On MemReady: Done; FETCH.
- Flags (add/sub/and only; all other instructions leave them unchanged):
  - z = (result == 0); n = result[DATA_W-1].
  - c = carry out of the DATA_W-bit add. For sub, computed as rX + ~operand + 1, so c = 1 means no borrow.
  - and clears c.
- Arithmetic wraps modulo 2^DATA_W.
- Writes with rX = 7 update PC. That value wins over the fetch increment, which has already occurred in FETCH.
- Latency with zero-wait memory:
  - mv/mvt/branch/nop: 2 cycles.
  - add/sub/and/ld/st: 3 cycles.
  - Each wait cycle adds 1.
- Run:
  - Sampled only in FETCH.
  - Dropping Run mid-instruction lets the instruction complete; the next fetch is held.
- Done is combinational from the state and is high for exactly one cycle per instruction.

Test Plan:
- Reset/fetch: Resetn = 0 then 1, Run = 1, MemReady = 1, memory[0] = mv r1,#5 (0x1205) -> fetch at ADDR = 0, r1 = 5, r7 = 1, Done pulses once, 2 cycles.
- ALU and flags: r1 = 0xFFFF, execute add r1,#1 -> r1 = 0, z = 1, c = 1, n = 0. Then sub r1,#1 -> r1 = 0xFFFF, n = 1, c = 0.
- mvt/and: mvt r2,#0xA5 -> r2 = 0xA500. Then and r2, r3 with r3 = 0x0F00 -> r2 = 0x0500, c = 0.
- Load/store with waits: MemReady low 2 cycles, st r4,[r5] with r4 = 0x1234, r5 = 0x40 -> W held 3 cycles, ADDR = 0x40, DOUT = 0x1234. Then ld r6,[r5] -> r6 = 0x1234.
- Branches: z = 1, beq with offset -3 at PC = 10 -> r7 = 8. Repeat with z = 0 -> r7 = 11. Also check bne, the cc/cs pair and never.
- Reset/Run/width: assert Resetn low during a pending Rd -> Rd = 0 immediately, state = FETCH. Drop Run mid-add -> add completes, no new Rd. Rerun the mvt and add-wrap cases with DATA_W = 32 -> 0xA5000000, and add wraps at 2^32.

Source files
------------

// File: rtl/proc_param.sv
// rtl/proc_param.sv - multicycle DATA_W-bit core fetching 16-bit instructions over a ready-handshaked port
// r7 doubles as the PC; add/sub/and set z/n/c, ld/st stall on MemReady.
module proc_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              MemReady,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              Rd,
  output logic              W,
  output logic              Done
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {FETCH, EXEC, ALU_WB, MEM} state_t;

  state_t            state;
  logic [DATA_W-1:0] r [8];
  logic [15:0]       ir;
  logic [DATA_W-1:0] g;
  logic              z, n, c;

  logic [2:0]        iii, rx, ry;
  logic              imm;
  logic [DATA_W-1:0] sext_imm, operand, opb, alu_res, mvt_val;
  logic [DATA_W:0]   sum;
  logic              is_sub, taken;

  assign iii      = ir[15:13];
  assign imm      = ir[12];
  assign rx       = ir[11:9];
  assign ry       = ir[2:0];
  assign sext_imm = {{(DATA_W-9){ir[8]}}, ir[8:0]};
  assign operand  = imm ? sext_imm : r[ry];
  assign mvt_val  = {ir[7:0], {(DATA_W-8){1'b0}}};

  // Subtract as rX + ~op + 1 so the carry out reads as "no borrow".
  assign is_sub  = (iii == OP_SUB);
  assign opb     = is_sub ? ~operand : operand;
  assign sum     = {1'b0, r[rx]} + {1'b0, opb} + {{DATA_W{1'b0}}, is_sub};
  assign alu_res = (iii == OP_AND) ? (r[rx] & operand) : sum[DATA_W-1:0];

  always_comb begin
    taken = 1'b0;
    case (rx)
      3'd0: taken = 1'b1;
      3'd1: taken = z;
      3'd2: taken = !z;
      3'd3: taken = !c;
      3'd4: taken = c;
      3'd5: taken = !n;
      3'd6: taken = n;
      default: taken = 1'b0;
    endcase
  end

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    Rd   = 1'b0;
    W    = 1'b0;
    ADDR = '0;
    DOUT = '0;
    Done = 1'b0;
    case (state)
      FETCH: begin
        if (Run && Resetn) begin
          Rd   = 1'b1;
          ADDR = r[7][ADDR_W-1:0];
        end
      end
      EXEC: begin
        if (iii == OP_MV || iii == OP_MVT || iii == OP_NOP) Done = 1'b1;
      end
      ALU_WB: Done = 1'b1;
      MEM: begin
        ADDR = r[ry][ADDR_W-1:0];
        if (iii == OP_LD) begin
          Rd = 1'b1;
        end else begin
          W    = 1'b1;
          DOUT = r[rx];
        end
        Done = MemReady;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= FETCH;
      ir    <= '0;
      g     <= '0;
      z     <= 1'b0;
      n     <= 1'b0;
      c     <= 1'b0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (Run && MemReady) begin
            ir    <= DIN[15:0];
            r[7]  <= r[7] + ONE;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= FETCH;
          case (iii)
            OP_MV: r[rx] <= operand;
            OP_MVT: begin
              if (imm) r[rx] <= mvt_val;
              else if (taken) r[7] <= r[7] + sext_imm;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              g     <= alu_res;
              z     <= (alu_res == '0);
              n     <= alu_res[DATA_W-1];
              c     <= (iii == OP_AND) ? 1'b0 : sum[DATA_W];
              state <= ALU_WB;
            end
            OP_LD, OP_ST: state <= MEM;
            default: ;
          endcase
        end
        ALU_WB: begin
          r[rx] <= g;
          state <= FETCH;
        end
        MEM: begin
          if (MemReady) begin
            if (iii == OP_LD) r[rx] <= DIN;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_param.sv
// tb/tb_proc_param.sv - directed bench for proc_param at DATA_W 16 and 32
module tb_proc_param;

  logic        Clock;
  logic        Resetn16, Run16, MemReady16, Rd16, W16, Done16;
  logic [15:0] DIN16, ADDR16, DOUT16;
  logic        Resetn32, Run32, MemReady32, Rd32, W32, Done32;
  logic [31:0] DIN32, DOUT32;
  logic [15:0] ADDR32;

  logic [15:0] mem16 [256];
  logic [31:0] mem32 [16];

  int checks = 0;
  int errors = 0;
  int cyc;

  proc_param #(.DATA_W(16), .ADDR_W(16)) u16 (
    .Clock(Clock), .Resetn(Resetn16), .Run(Run16), .DIN(DIN16), .MemReady(MemReady16),
    .ADDR(ADDR16), .DOUT(DOUT16), .Rd(Rd16), .W(W16), .Done(Done16)
  );

  proc_param #(.DATA_W(32), .ADDR_W(16)) u32 (
    .Clock(Clock), .Resetn(Resetn32), .Run(Run32), .DIN(DIN32), .MemReady(MemReady32),
    .ADDR(ADDR32), .DOUT(DOUT32), .Rd(Rd32), .W(W32), .Done(Done32)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign DIN16 = mem16[ADDR16[7:0]];
  assign DIN32 = mem32[ADDR32[3:0]];

  always @(posedge Clock) begin
    if (W16 && MemReady16) mem16[ADDR16[7:0]] <= DOUT16;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH through its Done cycle and checks its latency.
  task automatic run_instr(input bit sel32, input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (((sel32 ? Done32 : Done16) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    n++;
    tick();
    chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
  endtask

  int br_r7 [12] = '{35, 33, 34, 37, 38, 39, 0, 41, 44, 47, 48, 51};

  initial begin
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem32[i] = 32'h0;
    mem16[0]  = 16'h1205;  // mv r1,#5
    mem16[1]  = 16'h13FF;  // mv r1,#-1
    mem16[2]  = 16'h5201;  // add r1,#1
    mem16[3]  = 16'h7201;  // sub r1,#1
    mem16[4]  = 16'h34A5;  // mvt r2,#A5
    mem16[5]  = 16'h360F;  // mvt r3,#0F
    mem16[6]  = 16'h5201;  // add r1,#1
    mem16[7]  = 16'hC403;  // and r2,r3
    mem16[8]  = 16'h3812;  // mvt r4,#12
    mem16[9]  = 16'h5834;  // add r4,#34
    mem16[10] = 16'h1A40;  // mv r5,#40
    mem16[11] = 16'hA805;  // st r4,[r5]
    mem16[12] = 16'h8C05;  // ld r6,[r5]
    mem16[13] = 16'h7200;  // sub r1,#0
    mem16[14] = 16'h1E20;  // mv r7,#32
    mem16[32] = 16'h2002;  // b +2
    mem16[35] = 16'h23FD;  // beq -3
    mem16[33] = 16'h25FD;  // bne -3
    mem16[34] = 16'h2802;  // bcs +2
    mem16[37] = 16'h2605;  // bcc +5
    mem16[38] = 16'h2E05;  // bnever +5
    mem16[39] = 16'h5201;  // add r1,#1
    mem16[40] = 16'h23FD;  // beq -3
    mem16[41] = 16'h2402;  // bne +2
    mem16[44] = 16'h2602;  // bcc +2
    mem16[47] = 16'h2C02;  // bmi +2
    mem16[48] = 16'h2A02;  // bpl +2
    mem16[51] = 16'hE000;  // reserved
    mem16[52] = 16'h4603;  // add r3,r3
    mem32[0]  = 32'h000034A5;  // mvt r2,#A5
    mem32[1]  = 32'h000013FF;  // mv r1,#-1
    mem32[2]  = 32'h00005201;  // add r1,#1
    mem32[3]  = 32'h00004402;  // add r2,r2

    Resetn16 = 1'b0; Run16 = 1'b1; MemReady16 = 1'b1;
    Resetn32 = 1'b0; Run32 = 1'b1; MemReady32 = 1'b1;
    tick();
    tick();
    chk("rst_rd", Rd16, 1'b0);
    chk("rst_w", W16, 1'b0);
    chk("rst_done", Done16, 1'b0);
    chk("rst_addr", ADDR16, 16'h0);
    chk("rst_dout", DOUT16, 16'h0);
    chk("rst_pc", u16.r[7], 16'h0);

    Resetn16 = 1'b1;
    #1;
    chk("fetch_rd", Rd16, 1'b1);
    chk("fetch_addr", ADDR16, 16'h0);
    run_instr(1'b0, "mv_r1", 2);
    chk("mv_r1", u16.r[1], 16'h0005);
    chk("mv_pc", u16.r[7], 16'h0001);
    chk("mv_done_once", Done16, 1'b0);

    run_instr(1'b0, "mv_m1", 2);
    chk("mv_m1", u16.r[1], 16'hFFFF);
    run_instr(1'b0, "add_wrap", 3);
    chk("add_r1", u16.r[1], 16'h0000);
    chk("add_flags", {u16.z, u16.n, u16.c}, 3'b101);
    run_instr(1'b0, "sub", 3);
    chk("sub_r1", u16.r[1], 16'hFFFF);
    chk("sub_flags", {u16.z, u16.n, u16.c}, 3'b010);

    run_instr(1'b0, "mvt_r2", 2);
    chk("mvt_r2", u16.r[2], 16'hA500);
    run_instr(1'b0, "mvt_r3", 2);
    chk("mvt_r3", u16.r[3], 16'h0F00);
    run_instr(1'b0, "add_c", 3);
    chk("add_c_set", u16.c, 1'b1);
    run_instr(1'b0, "and", 3);
    chk("and_r2", u16.r[2], 16'h0500);
    chk("and_flags", {u16.z, u16.n, u16.c}, 3'b000);

    run_instr(1'b0, "mvt_r4", 2);
    run_instr(1'b0, "add_r4", 3);
    chk("r4", u16.r[4], 16'h1234);
    run_instr(1'b0, "mv_r5", 2);
    chk("r5", u16.r[5], 16'h0040);

    // st r4,[r5] with two wait cycles on the data access
    tick();
    MemReady16 = 1'b0;
    tick();
    chk("st_w1", W16, 1'b1);
    chk("st_addr", ADDR16, 16'h0040);
    chk("st_dout", DOUT16, 16'h1234);
    chk("st_rd_low", Rd16, 1'b0);
    chk("st_wait_done", Done16, 1'b0);
    tick();
    chk("st_w2", W16, 1'b1);
    tick();
    chk("st_w3", W16, 1'b1);
    MemReady16 = 1'b1;
    #1;
    chk("st_done", Done16, 1'b1);
    tick();
    chk("st_w_drop", W16, 1'b0);
    chk("st_mem", mem16[64], 16'h1234);

    run_instr(1'b0, "ld", 3);
    chk("ld_r6", u16.r[6], 16'h1234);
    run_instr(1'b0, "sub0", 3);
    chk("sub0_flags", {u16.z, u16.n, u16.c}, 3'b101);
    run_instr(1'b0, "mv_pc", 2);
    chk("mv_pc_r7", u16.r[7], 16'd32);
    chk("mv_pc_addr", ADDR16, 16'd32);

    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        run_instr(1'b0, "add_r1b", 3);
        chk("add_r1b", u16.r[1], 16'h0001);
        chk("add_r1b_flags", {u16.z, u16.n, u16.c}, 3'b000);
      end else begin
        run_instr(1'b0, $sformatf("br%0d", i), 2);
        chk($sformatf("br%0d_pc", i), u16.r[7], 16'(br_r7[i]));
      end
    end
    run_instr(1'b0, "nop", 2);
    chk("nop_pc", u16.r[7], 16'd52);
    chk("nop_flags", {u16.z, u16.n, u16.c}, 3'b000);

    // Drop Run while add r3,r3 is in flight
    tick();
    Run16 = 1'b0;
    chk("run_exec_done", Done16, 1'b0);
    tick();
    chk("run_wb_done", Done16, 1'b1);
    tick();
    chk("run_r3", u16.r[3], 16'h1E00);
    chk("run_no_rd", Rd16, 1'b0);
    tick();
    chk("run_no_rd2", Rd16, 1'b0);
    chk("run_pc", u16.r[7], 16'd53);

    // Reset lands on a stalled fetch
    MemReady16 = 1'b0;
    Run16 = 1'b1;
    #1;
    chk("pend_rd", Rd16, 1'b1);
    chk("pend_addr", ADDR16, 16'd53);
    tick();
    chk("pend_rd2", Rd16, 1'b1);
    #2;
    Resetn16 = 1'b0;
    #1;
    chk("arst_rd", Rd16, 1'b0);
    chk("arst_addr", ADDR16, 16'h0);
    chk("arst_pc", u16.r[7], 16'h0);
    chk("arst_r3", u16.r[3], 16'h0);

    // 32-bit instance
    tick();
    Resetn32 = 1'b1;
    #1;
    run_instr(1'b1, "w32_mvt", 2);
    chk("w32_mvt", u32.r[2], 32'hA500_0000);
    run_instr(1'b1, "w32_mv", 2);
    chk("w32_mv", u32.r[1], 32'hFFFF_FFFF);
    run_instr(1'b1, "w32_add", 3);
    chk("w32_add", u32.r[1], 32'h0);
    chk("w32_add_flags", {u32.z, u32.n, u32.c}, 3'b101);
    run_instr(1'b1, "w32_dbl", 3);
    chk("w32_dbl", u32.r[2], 32'h4A00_0000);
    chk("w32_dbl_flags", {u32.z, u32.n, u32.c}, 3'b001);
    chk("w32_pc", u32.r[7], 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
